// File: rtl/elev_dispatch.sv
// rtl/elev_dispatch.sv - SCAN request scheduler and floor/door sequencer for the elevator car
// Optional door hold input is enabled by defining ELEV_DOOR_HOLD_EN.
module elev_dispatch #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 3,
  parameter int DOOR_CYCLES   = 4,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  output logic [FW-1:0]         floor_sel,
  output logic                  door,
  output logic                  moving,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]         DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DWELL
  } state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d, floor_nxt;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic [NUM_FLOORS-1:0] req, cur_oh, nxt_oh;
  logic                  above, below, sel_up, here, hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign req       = pending_q | call_btn;
  assign cur_oh    = ONE << floor_q;
  assign floor_nxt = dir_up_q ? floor_q + 1'b1 : floor_q - 1'b1;
  assign nxt_oh    = ONE << floor_nxt;
  assign here      = |(call_btn & cur_oh);

  // SCAN: keep going up while anything is above, otherwise prefer down.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_q)) above = above | pending_q[i];
      if (i < int'(floor_q)) below = below | pending_q[i];
    end
    sel_up = above & (dir_up_q | ~below);
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    pending_d = req;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    case (state_q)
      S_IDLE: begin
        pending_d = req & ~cur_oh;
        if (here) begin
          state_d = S_DWELL;
          dcnt_d  = DOOR_LOAD;
        end else if (|pending_q) begin
          state_d  = S_MOVE;
          dir_up_d = sel_up;
          tcnt_d   = TRAVEL_LOAD;
        end
      end
      S_MOVE: begin
        if (tcnt_q != '0) begin
          tcnt_d = tcnt_q - 1'b1;
        end else begin
          floor_d = floor_nxt;
          // Arrival looks at this cycle's buttons too, so a same-edge call is absorbed.
          if (|(req & nxt_oh)) begin
            pending_d = req & ~nxt_oh;
            state_d   = S_DWELL;
            dcnt_d    = DOOR_LOAD;
          end else begin
            tcnt_d = TRAVEL_LOAD;
          end
        end
      end
      S_DWELL: begin
        pending_d = req & ~cur_oh;
        if (here || hold) begin
          dcnt_d = DOOR_LOAD;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - 1'b1;
        end else if (|pending_q) begin
          state_d  = S_MOVE;
          dir_up_d = sel_up;
          tcnt_d   = TRAVEL_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign floor_sel = floor_q;
  assign door      = (state_q != S_MOVE);
  assign moving    = (state_q == S_MOVE);
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;

endmodule
